// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection, jal link capture and ROM addressing.
// Optional retired/redirect performance counters are built when IFETCH_PERF_EN is defined.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ROM_AW   = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic [31:0]       rom_data,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [31:0]       Instruction,
    input  logic              Branch,
    input  logic              nBranch,
    input  logic              Jmp,
    input  logic              Jal,
    input  logic              Jr,
    input  logic              Zero,
    input  logic [31:0]       Addr_result,
    input  logic [31:0]       Read_data_1,
    output logic [31:0]       pc,
    output logic [31:0]       branch_base_addr,
`ifdef IFETCH_PERF_EN
    output logic [31:0]       retired_cnt,
    output logic [31:0]       redirect_cnt,
`endif
    output logic [31:0]       link_addr
);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HOLD} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_link;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_run;
    logic        w_advance;
    logic        w_taken;
    logic        w_unused;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // BOOT lasts exactly one edge so the ROM can register the word at RESET_PC.
    always_comb begin
        w_state_nxt = S_BOOT;
        case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = fetch_en ? S_RUN : S_HOLD;
            S_HOLD:  w_state_nxt = fetch_en ? S_RUN : S_HOLD;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_comb begin
        w_run       = (r_state == S_RUN);
        w_advance   = w_run & fetch_en;
        Instruction = w_run ? rom_data : 32'h0000_0000;
    end

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_taken    = (Branch & Zero) | (nBranch & ~Zero);

    always_comb begin
        w_next_pc = r_pc;
        if (w_run) begin
            if (Jr) begin
                w_next_pc = {Read_data_1[31:2], 2'b00};
            end else if (Jmp | Jal) begin
                w_next_pc = {w_pc_plus4[31:28], Instruction[25:0], 2'b00};
            end else if (w_taken) begin
                w_next_pc = {Addr_result[31:2], 2'b00};
            end else begin
                w_next_pc = w_pc_plus4;
            end
        end
    end

    // Addressing the ROM with next_pc makes the registered word line up with the updated pc.
    assign rom_addr = w_next_pc[ROM_AW+1:2];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc   <= RESET_PC;
            r_link <= 32'h0000_0000;
        end else if (w_advance) begin
            r_pc <= w_next_pc;
            if (Jal) begin
                r_link <= w_pc_plus4;
            end
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] r_retired;
    logic [31:0] r_redirect;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_retired  <= 32'h0000_0000;
            r_redirect <= 32'h0000_0000;
        end else if (w_advance) begin
            r_retired <= r_retired + 32'd1;
            if (w_next_pc != w_pc_plus4) begin
                r_redirect <= r_redirect + 32'd1;
            end
        end
    end

    assign retired_cnt  = r_retired;
    assign redirect_cnt = r_redirect;
`endif

    assign w_unused         = ^{Read_data_1[1:0], Addr_result[1:0]};
    assign pc               = r_pc;
    assign branch_base_addr = w_pc_plus4;
    assign link_addr        = r_link;

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: the driver queues the expected per-cycle view,
// a negedge monitor pops and compares it against the DUT outputs.
module tb_ifetch_unit;

    logic        clock;
    logic        reset;
    logic        fetch_en;
    logic [31:0] rom_data;
    logic [13:0] rom_addr;
    logic [31:0] Instruction;
    logic        Branch, nBranch, Jmp, Jal, Jr, Zero;
    logic [31:0] Addr_result, Read_data_1;
    logic [31:0] pc, branch_base_addr, link_addr;
`ifdef IFETCH_PERF_EN
    logic [31:0] retired_cnt, redirect_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       nm;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] link;
        logic [13:0] ra;
        bit          perf;
        logic [31:0] ret;
        logic [31:0] red;
    } exp_t;

    exp_t q[$];

    ifetch_unit #(.RESET_PC(32'h0000_0000), .ROM_AW(14)) dut (
        .clock            (clock),
        .reset            (reset),
        .fetch_en         (fetch_en),
        .rom_data         (rom_data),
        .rom_addr         (rom_addr),
        .Instruction      (Instruction),
        .Branch           (Branch),
        .nBranch          (nBranch),
        .Jmp              (Jmp),
        .Jal              (Jal),
        .Jr               (Jr),
        .Zero             (Zero),
        .Addr_result      (Addr_result),
        .Read_data_1      (Read_data_1),
        .pc               (pc),
        .branch_base_addr (branch_base_addr),
`ifdef IFETCH_PERF_EN
        .retired_cnt      (retired_cnt),
        .redirect_cnt     (redirect_cnt),
`endif
        .link_addr        (link_addr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ROM image: word 8 holds a jal with target field 26'h100, every other word tags its own address.
    function automatic logic [31:0] rw(input logic [13:0] a);
        return (a == 14'd8) ? 32'h0C00_0100 : (32'h8C00_0000 | {18'h0, a});
    endfunction

    always @(posedge clock) rom_data <= rw(rom_addr);

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.nm, "pc", pc, e.pc);
            chk(e.nm, "instr", Instruction, e.instr);
            chk(e.nm, "link", link_addr, e.link);
            chk(e.nm, "rom_addr", {18'h0, rom_addr}, {18'h0, e.ra});
            chk(e.nm, "bba", branch_base_addr, e.pc + 32'd4);
`ifdef IFETCH_PERF_EN
            if (e.perf) begin
                chk(e.nm, "retired", retired_cnt, e.ret);
                chk(e.nm, "redirect", redirect_cnt, e.red);
            end
`endif
        end
    end

    task automatic cyc(input string nm, input logic [31:0] epc, input logic [31:0] ei,
                       input logic [31:0] el, input logic [13:0] era,
                       input bit perf = 1'b0, input logic [31:0] eret = 32'h0, input logic [31:0] ered = 32'h0);
        exp_t e;
        e.nm = nm; e.pc = epc; e.instr = ei; e.link = el; e.ra = era;
        e.perf = perf; e.ret = eret; e.red = ered;
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        Branch = 0; nBranch = 0; Jmp = 0; Jal = 0; Jr = 0; Zero = 0;
        Addr_result = 32'h0; Read_data_1 = 32'h0;
    endtask

    logic [31:0] p;

    initial begin
        reset = 1'b1;
        fetch_en = 1'b1;
        clr();
        @(posedge clock);
        #1;
        cyc("rst", 32'h0, 32'h0, 32'h0, 14'd0);
        reset = 1'b0;
        cyc("boot", 32'h0, 32'h0, 32'h0, 14'd0);
        cyc("run0", 32'h0, rw(14'd0), 32'h0, 14'd1);
        cyc("run4", 32'h4, rw(14'd1), 32'h0, 14'd2);
        cyc("run8", 32'h8, rw(14'd2), 32'h0, 14'd3);
        cyc("runC", 32'hC, rw(14'd3), 32'h0, 14'd4);

        Branch = 1; Zero = 1; Addr_result = 32'h43;
        cyc("beq_t", 32'h10, rw(14'd4), 32'h0, 14'h10);
        Zero = 0; Addr_result = 32'h80;
        cyc("beq_nt", 32'h40, rw(14'h10), 32'h0, 14'h11);
        Branch = 0; nBranch = 1; Zero = 0; Addr_result = 32'h10;
        cyc("bne_t", 32'h44, rw(14'h11), 32'h0, 14'h4);
        Zero = 1; Addr_result = 32'h80;
        cyc("bne_nt", 32'h10, rw(14'h4), 32'h0, 14'h5);
        Branch = 1; nBranch = 1; Zero = 0; Addr_result = 32'h20;
        cyc("both_br", 32'h14, rw(14'h5), 32'h0, 14'h8);
        clr(); Jal = 1;
        cyc("jal", 32'h20, 32'h0C00_0100, 32'h0, 14'h100);
        clr(); Jr = 1; Read_data_1 = 32'h27; Jmp = 1; Branch = 1; Zero = 1; Addr_result = 32'h80;
        cyc("jr_wins", 32'h400, rw(14'h100), 32'h24, 14'h9);
        clr();
        cyc("after_jr", 32'h24, rw(14'h9), 32'h24, 14'hA);

        fetch_en = 0;
        cyc("drop_en", 32'h28, rw(14'hA), 32'h24, 14'hB);
        Jal = 1; Jr = 1; Read_data_1 = 32'h100;
        cyc("hold1", 32'h28, 32'h0, 32'h24, 14'hA);
        clr();
        cyc("hold2", 32'h28, 32'h0, 32'h24, 14'hA);
        fetch_en = 1;
        cyc("resume", 32'h28, 32'h0, 32'h24, 14'hA);
        cyc("resumed", 32'h28, rw(14'hA), 32'h24, 14'hB);
        Jr = 1; Read_data_1 = 32'h400;
        cyc("to400", 32'h2C, rw(14'hB), 32'h24, 14'h100);
        clr();

        #1;
        reset = 1'b1;
        cyc("arst", 32'h0, 32'h0, 32'h0, 14'd0);
        cyc("arst_hold", 32'h0, 32'h0, 32'h0, 14'd0);
        reset = 1'b0;
        cyc("boot2", 32'h0, 32'h0, 32'h0, 14'd0);
        Jr = 1; Read_data_1 = 32'hFFFF_FFFF;
        cyc("to_top", 32'h0, rw(14'd0), 32'h0, 14'h3FFF);
        clr();
        cyc("top", 32'hFFFF_FFFC, rw(14'h3FFF), 32'h0, 14'd0);
        cyc("wrap", 32'h0, rw(14'd0), 32'h0, 14'd1);

        reset = 1'b1;
        cyc("rst3", 32'h0, 32'h0, 32'h0, 14'd0, 1'b1, 32'd0, 32'd0);
        reset = 1'b0;
        cyc("boot3", 32'h0, 32'h0, 32'h0, 14'd0);
        p = 32'h0;
        for (int i = 0; i < 5; i++) begin
            cyc("seqA", p, rw(p[15:2]), 32'h0, p[15:2] + 14'd1);
            p = p + 32'd4;
        end
        Branch = 1; Zero = 1; Addr_result = 32'h100;
        cyc("br1", 32'h14, rw(14'h5), 32'h0, 14'h40);
        clr();
        fetch_en = 0;
        cyc("h0", 32'h100, rw(14'h40), 32'h0, 14'h41);
        fetch_en = 1;
        cyc("h1", 32'h100, 32'h0, 32'h0, 14'h40);
        p = 32'h100;
        for (int i = 0; i < 5; i++) begin
            cyc("seqB", p, rw(p[15:2]), 32'h0, p[15:2] + 14'd1);
            p = p + 32'd4;
        end
        nBranch = 1; Zero = 0; Addr_result = 32'h200;
        cyc("br2", 32'h114, rw(14'h45), 32'h0, 14'h80);
        clr();
        fetch_en = 0;
        cyc("perf", 32'h200, rw(14'h80), 32'h0, 14'h81, 1'b1, 32'd12, 32'd2);

        @(negedge clock);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
